// File: rtl/shift_frame_pkg.sv
// shift_frame shared definitions: FSM states, shift directions
// and the frame-length clamp used when a counted frame starts.
package shift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // A zero or oversized length means a full-width frame.
  function automatic int frame_len(input int cnt, input int w);
    return (cnt == 0 || cnt > w) ? w : cnt;
  endfunction

endpackage

// File: rtl/shift_frame_ctrl.sv
// shift_frame control: frame FSM, bit down-counter, latched direction.
// Decides each edge whether the datapath loads, shifts or holds.
module shift_frame_ctrl
  import shift_pkg::*;
#(
  parameter  int W  = 8,
  localparam int CW = $clog2(W + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          ld_i,
  input  logic          sh_i,
  input  logic          dir_i,
  input  logic [CW-1:0] cnt_i,
  output logic          shift_en,
  output logic          load_en,
  output logic          busy,
  output logic          done,
  output logic          dir_q
);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          idle;

  assign idle     = (state_q == ST_IDLE);
  assign busy     = ~idle;
  assign done     = (state_q == ST_DONE);
  assign load_en  = idle & ~start_i & ld_i;
  assign shift_en = (state_q == ST_SHIFT)
                  | (idle & ~start_i & ~ld_i & sh_i);

  // Frame sequencing: latch dir/length on START, count shifts down.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_RIGHT;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            dir_q   <= dir_i;
            cnt_q   <= CW'(frame_len(int'(cnt_i), W));
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1))
            state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/shift_frame.sv
// shift_frame top: W-bit shift register with counted frame transfers.
// Define SHIFT_ROTATE_EN to add the ROT port (rotate instead of SIN).
module shift_frame
  import shift_pkg::*;
#(
  parameter  int         W       = 8,
  parameter  logic [W-1:0] RST_VAL = '0,
  localparam int         CW      = $clog2(W + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          SIN,
  input  logic [W-1:0]  PIN,
  input  logic          LD,
  input  logic          SH,
  input  logic          START,
  input  logic          DIR,
  input  logic [CW-1:0] CNT,
`ifdef SHIFT_ROTATE_EN
  input  logic          ROT,
`endif
  output logic          SOUT,
  output logic [W-1:0]  POUT,
  output logic          BUSY,
  output logic          DONE
);

  logic [W-1:0] q_q, q_d;
  logic         shift_en, load_en, busy, done, dir_q;
  logic         eff_dir, rot, in_bit;

  shift_frame_ctrl #(.W(W)) u_ctrl (
    .clk_i    (CLK),
    .rst_i    (RST),
    .start_i  (START),
    .ld_i     (LD),
    .sh_i     (SH),
    .dir_i    (DIR),
    .cnt_i    (CNT),
    .shift_en (shift_en),
    .load_en  (load_en),
    .busy     (busy),
    .done     (done),
    .dir_q    (dir_q)
  );

`ifdef SHIFT_ROTATE_EN
  assign rot = ROT;
`else
  assign rot = 1'b0;
`endif

  // Frames use the direction captured at START; idle uses live DIR.
  assign eff_dir = busy ? dir_q : DIR;
  assign in_bit  = rot ? (eff_dir == DIR_LEFT ? q_q[W-1] : q_q[0])
                       : SIN;

  // Next register value: parallel load beats shift beats hold.
  always_comb begin
    q_d = q_q;
    if (load_en)
      q_d = PIN;
    else if (shift_en)
      q_d = (eff_dir == DIR_LEFT) ? {q_q[W-2:0], in_bit}
                                  : {in_bit, q_q[W-1:1]};
  end

  // Datapath register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) q_q <= RST_VAL;
    else     q_q <= q_d;
  end

  assign SOUT = (eff_dir == DIR_LEFT) ? q_q[W-1] : q_q[0];
  assign POUT = q_q;
  assign BUSY = busy;
  assign DONE = done;

endmodule

// File: tb/tb_shift_frame.sv
// Self-checking bench for shift_frame against a behavioural model.
// Rotate checks are included when SHIFT_ROTATE_EN is defined.
module tb_shift_frame;

  localparam int           W  = 8;
  localparam int           CW = $clog2(W + 1);
  localparam logic [W-1:0] RV = '0;

  logic          CLK = 1'b0;
  logic          RST, SIN, LD, SH, START, DIR;
  logic [W-1:0]  PIN;
  logic [CW-1:0] CNT;
`ifdef SHIFT_ROTATE_EN
  logic          ROT;
`endif
  logic          SOUT, BUSY, DONE;
  logic [W-1:0]  POUT;

  shift_frame #(.W(W), .RST_VAL(RV)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .SIN   (SIN),
    .PIN   (PIN),
    .LD    (LD),
    .SH    (SH),
    .START (START),
    .DIR   (DIR),
    .CNT   (CNT),
`ifdef SHIFT_ROTATE_EN
    .ROT   (ROT),
`endif
    .SOUT  (SOUT),
    .POUT  (POUT),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  always #5 CLK = ~CLK;

  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] m_q;
  logic         r;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Spec rule: right inserts at MSB, left inserts at LSB.
  function automatic logic [W-1:0] ref_shift(logic [W-1:0] q,
      logic dir, logic sin, logic rot);
    logic b;
    b = rot ? (dir ? q[W-1] : q[0]) : sin;
    if (dir) return W'((q << 1) | W'(b));
    return (q >> 1) | (W'(b) << (W - 1));
  endfunction

  function automatic logic pick_rot(input int rmode);
`ifdef SHIFT_ROTATE_EN
    return (rmode == 2) ? 1'($urandom) : 1'(rmode);
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive_rot(input logic v);
`ifdef SHIFT_ROTATE_EN
    ROT = v;
`endif
    r = v;
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_idle;
    LD = 1'b0; SH = 1'b0; START = 1'b0;
    drive_rot(1'b0);
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_pout"}, 32'(POUT), 32'(m_q));
    chk({tag, "_sout"}, 32'(SOUT), 32'(DIR ? m_q[W-1] : m_q[0]));
    chk({tag, "_busy"}, 32'(BUSY), 32'(0));
    chk({tag, "_done"}, 32'(DONE), 32'(0));
  endtask

  task automatic do_ld(input logic [W-1:0] v);
    PIN = v; LD = 1'b1; SH = 1'($urandom);
    step;
    LD = 1'b0; SH = 1'b0;
    m_q = v;
    idle_chk("ld");
  endtask

  task automatic do_sh(input logic d, input logic s, input int rmode);
    DIR = d; SIN = s; SH = 1'b1;
    drive_rot(pick_rot(rmode));
    step;
    SH = 1'b0;
    m_q = ref_shift(m_q, d, s, r);
    drive_rot(1'b0);
    idle_chk("sh");
  endtask

  // Counted frame; mid-frame requests and DIR changes are noise.
  task automatic run_frame(input int cnt, input logic d,
      input logic with_ld, input int abort_at,
      input int smode, input int rmode);
    int   n;
    logic ldir;
    n    = (cnt == 0 || cnt > W) ? W : cnt;
    ldir = d;
    CNT = CW'(cnt); DIR = d; START = 1'b1;
    LD = with_ld; SH = 1'($urandom); PIN = W'($urandom);
    step;
    chk("fr_start_pout", 32'(POUT), 32'(m_q));
    chk("fr_start_busy", 32'(BUSY), 32'(1));
    chk("fr_start_done", 32'(DONE), 32'(0));
    for (int i = 1; i <= n; i++) begin
      DIR = 1'($urandom); LD = 1'($urandom);
      SH = 1'($urandom); START = 1'($urandom);
      PIN = W'($urandom);
      SIN = (smode < 0) ? 1'($urandom) : 1'(smode);
      drive_rot(pick_rot(rmode));
      step;
      m_q = ref_shift(m_q, ldir, SIN, r);
      chk("fr_pout", 32'(POUT), 32'(m_q));
      chk("fr_sout", 32'(SOUT), 32'(ldir ? m_q[W-1] : m_q[0]));
      chk("fr_busy", 32'(BUSY), 32'(1));
      chk("fr_done", 32'(DONE), 32'(i == n));
      if (i == abort_at) begin
        #1 RST = 1'b1;
        #1;
        m_q = RV;
        chk("abort_pout", 32'(POUT), 32'(RV));
        chk("abort_busy", 32'(BUSY), 32'(0));
        chk("abort_done", 32'(DONE), 32'(0));
        set_idle;
        #1 RST = 1'b0;
        for (int k = 0; k < 3; k++) begin
          DIR = 1'($urandom); SIN = 1'($urandom);
          step;
          idle_chk("abort_idle");
        end
        return;
      end
    end
    DIR = 1'($urandom); START = 1'($urandom);
    LD = 1'($urandom); SH = 1'($urandom);
    step;
    set_idle;
    idle_chk("fr_end");
  endtask

  initial begin
    RST = 1'b1; SIN = 1'b0; LD = 1'b0; SH = 1'b0; START = 1'b0;
    DIR = 1'b0; PIN = '0; CNT = '0;
    drive_rot(1'b0);
    m_q = RV;
    #3;
    chk("rst_pout", 32'(POUT), 32'(RV));
    chk("rst_sout", 32'(SOUT), 32'(RV[0]));
    chk("rst_busy", 32'(BUSY), 32'(0));
    chk("rst_done", 32'(DONE), 32'(0));
    step; step;
    RST = 1'b0;

    do_ld(8'hA5);
    chk("t2_ld_val", 32'(POUT), 32'h A5);
    chk("t2_ld_sout", 32'(SOUT), 32'(1));
    do_sh(1'b0, 1'b1, 0);
    chk("t2_sh_val", 32'(POUT), 32'h D2);
    chk("t2_sh_sout", 32'(SOUT), 32'(0));

    #1 RST = 1'b1;
    #1;
    chk("t1_async_pout", 32'(POUT), 32'(0));
    chk("t1_async_sout", 32'(SOUT), 32'(0));
    chk("t1_async_busy", 32'(BUSY), 32'(0));
    #1 RST = 1'b0;
    m_q = RV;

    do_ld(8'h81);
    run_frame(0, 1'b0, 1'b0, 0, 0, 0);
    chk("t3_final", 32'(POUT), 32'h 00);

    do_ld(8'hF0);
    run_frame(3, 1'b1, 1'b1, 0, 1, 0);
    chk("t4_final", 32'(POUT), 32'h 87);

    do_ld(8'h5A);
    run_frame(12, 1'b1, 1'b0, 0, -1, 0);
    do_ld(8'h3C);
    run_frame(12, 1'b0, 1'b0, 4, -1, 0);
    do_ld(8'hC3);
    run_frame(1, 1'b1, 1'b0, 0, -1, 0);
    run_frame(W, 1'b0, 1'b0, 0, -1, 0);

    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 3))
        0: do_ld(W'($urandom));
        1: do_sh(1'($urandom), 1'($urandom), 2);
        2: run_frame(int'($urandom_range(0, (1 << CW) - 1)),
                     1'($urandom), 1'($urandom), 0, -1, 2);
        default: begin
          DIR = 1'($urandom); SIN = 1'($urandom);
          PIN = W'($urandom);
          step;
          idle_chk("hold");
        end
      endcase
    end

`ifdef SHIFT_ROTATE_EN
    do_ld(8'h01);
    run_frame(8, 1'b0, 1'b0, 0, -1, 1);
    chk("t6_rot8", 32'(POUT), 32'h 01);
    run_frame(1, 1'b0, 1'b0, 0, -1, 1);
    chk("t6_rot1", 32'(POUT), 32'h 80);
    do_sh(1'b1, 1'($urandom), 1);
    chk("t6_rot_sh", 32'(POUT), 32'h 01);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_frame.md
Name: shift_frame

Overview:
Parametrised successor to the 8-bit serial/parallel shift register. Adds configurable width, run-time shift direction, and a counted frame-transfer mode with BUSY/DONE handshake. Sits between datapath registers and serial links (SPI-style serialiser/deserialiser) under control of a higher-level controller. Single-shot SH and parallel LD remain available when idle.

Parameters:
W, 8, register width in bits; legal range W >= 2
RST_VAL, 0, W-bit value loaded into the register on reset
CW, $clog2(W+1), width of CNT; derived, not overridden

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
SIN  in  1  serial data in
PIN  in  W  parallel load data
LD  in  1  parallel load request (IDLE only)
SH  in  1  single-bit shift request (IDLE only)
START  in  1  begin counted frame (IDLE only)
DIR  in  1  0 = shift right (SIN enters MSB, SOUT = Q[0]); 1 = shift left (SIN enters LSB, SOUT = Q[W-1])
CNT  in  CW  frame length in bits; 0 or >W means W
SOUT  out  1  serial data out, combinational from Q per active direction
POUT  out  W  register contents Q
BUSY  out  1  high in SHIFT and DONE states
DONE  out  1  one-cycle pulse, frame complete

Behaviour:
- Reset (async, RST=1): Q=RST_VAL, state=IDLE, counter=0, latched dir=0; BUSY=0, DONE=0, POUT=RST_VAL, SOUT=RST_VAL[0]. Reset mid-frame aborts it with no DONE pulse.
- States: IDLE, SHIFT, DONE.
- IDLE, priority START > LD > SH at a rising edge:
  - START: latch DIR, counter = N, where N = W if CNT==0 or CNT>W, else N = CNT. Go to SHIFT. Q is unchanged on this edge.
  - LD: Q <= PIN.
  - SH: one shift using the live DIR.
  - None asserted: hold.
- Shift right: Q <= {SIN, Q[W-1:1]}. Shift left: Q <= {Q[W-2:0], SIN}.
- SHIFT: each edge shifts once using the latched dir and decrements the counter. The edge that takes the counter to 0 moves to DONE. Exactly N shifts occur.
- DONE: DONE=1 and BUSY=1 for exactly one cycle, then IDLE on the next edge.
- Latency: START sampled at edge t0. Shifts occur at t1..tN. DONE is high between tN and tN+1. The next START is accepted at tN+1 at the earliest.
- In SHIFT and DONE, LD, SH and START are ignored. Changing DIR mid-frame has no effect on the frame.
- SOUT follows the latched dir while BUSY, and the live DIR while idle.
- SIN is sampled at every shifting edge. The caller holds SIN stable around CLK.

Optional Feature:
SHIFT_ROTATE_EN
- Defined: adds input port ROT (1 bit). When ROT=1, the bit entering the register is the bit leaving it (Q[0] for right, Q[W-1] for left) instead of SIN. ROT is sampled per edge and applies to both SH and frame shifts. ROT has no effect on LD or reset.
- Undefined: no ROT port; SIN is always the incoming bit.

Decomposition:
- Package shift_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2
  - direction constants DIR_RIGHT=1'b0, DIR_LEFT=1'b1
  - frame-length clamp function
- Sub-module shift_frame_ctrl: FSM, down-counter and latched dir. Outputs shift_en, load_en, busy, done, dir_q.
- Top level holds the W-bit datapath register and the SOUT mux.

Test Plan:
1. W=8, RST_VAL=0, RST pulse mid-cycle -> POUT=0x00, SOUT=0, BUSY=0, DONE=0 immediately, without waiting for a CLK edge.
2. LD with PIN=0xA5, then SH with DIR=0 and SIN=1 -> POUT=0xA5 then 0xD2; SOUT 1 then 0.
3. Load 0x81, then START with CNT=0, DIR=0, SIN=0 -> BUSY high 9 cycles; SOUT sequence 1,0,0,0,0,0,0,1; DONE pulses once on cycle 9; final POUT=0x00.
4. Load 0xF0, then START with CNT=3, DIR=1, SIN=1, toggling DIR and asserting LD/SH mid-frame -> POUT goes 0xE1, 0xC3, 0x87; requests ignored; DONE once; START in the same cycle as LD -> START wins, Q unchanged.
5. START with CNT=12 (>W) -> exactly 8 shifts. RST asserted after the 4th shift -> POUT=0x00, BUSY=0, no DONE pulse.
6. With SHIFT_ROTATE_EN defined: load 0x01, ROT=1, DIR=0 -> CNT=8 returns POUT=0x01; CNT=1 gives 0x80; SH with DIR=1 from 0x80 gives 0x01.
